cache_credit_sched: RTL and testbench
=====================================

Name: cache_credit_sched

Overview:
- Grants one requester per cycle onto a shared cache request port, selecting by round-robin.
- Caps outstanding (unanswered) requests per requester with a credit counter.
- Sits in front of the cache request/response arbiter. Its select output steers the request mux, and response fires return credits.
- Supports a flush handshake that blocks new grants until all outstanding requests have been answered.

Parameters:
- NUM_REQS, 4: number of requesters, at least 2.
- MAX_PENDING, 4: maximum outstanding requests per requester, at least 1.
- PERF_WIDTH, 16: width of each stall counter (optional feature only).
- Derived constant SEL_W = max(1, CLOG2(NUM_REQS)).
- Derived constant CNT_W = CLOG2(MAX_PENDING+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid_in  in  NUM_REQS  per-requester request valid.
- req_ready_in  out  NUM_REQS  per-requester ready; one-hot or zero.
- req_valid_out  out  1  granted request valid toward the cache.
- req_sel_out  out  SEL_W  index of the granted requester.
- req_ready_out  in  1  cache accepts the request.
- rsp_fire_in  in  1  a response was consumed this cycle.
- rsp_sel_in  in  SEL_W  requester owning that response.
- flush_req_in  in  1  request a drain; level, sampled in RUN.
- flush_done_out  out  1  one-cycle pulse when the drain completes.
- idle_out  out  1  all pending counters are zero.
- stall_cnt_out  out  NUM_REQS*PERF_WIDTH  only with CACHE_SCHED_PERF_EN.

Behaviour:
- Reset (asynchronous, active-high): pending[i]=0, rr_ptr=0, lock_valid=0, state=RUN.
- While reset is high, req_valid_out=0, req_ready_in=0, flush_done_out=0, idle_out=1.
- Eligibility: eligible[i] = req_valid_in[i] && pending[i] < MAX_PENDING. There is no same-cycle credit bypass: a response that frees a credit makes the requester eligible the next cycle.
- Arbitration: the winner is the first eligible index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQS.
- req_valid_out = state==RUN && (lock_valid || any eligible).
- req_sel_out = lock_valid ? lock_sel : winner.
- req_ready_in[req_sel_out] = req_valid_out && req_ready_out; all other bits are 0.
- Fire = req_valid_out && req_ready_out. On fire, rr_ptr <= (sel+1) mod NUM_REQS.
- Grant lock:
  - If req_valid_out && !req_ready_out: lock_valid<=1, lock_sel<=req_sel_out. The selection stays stable until fire.
  - Cleared on fire.
  - Requesters must hold valid and data while unaccepted.
  - A locked requester is exempt from re-checking credit, because its credit was reserved when the lock was taken.
- Zero latency: combinational grant and no data storage in the block.
- Counters: pending[sel] increments on request fire; pending[rsp_sel_in] decrements on rsp_fire_in.
  - Both events to the same index in one cycle: the counter is unchanged.
  - Decrement at 0 is a protocol error: assertion fires, counter holds 0.
  - Increment at MAX_PENDING cannot happen, by eligibility.
- idle_out = all pending==0; this output is registered-state combinational.
- State machine:
  - RUN: when flush_req_in=1 and no lock is held, go to DRAIN. With a lock held, stay in RUN until the locked request fires, then go to DRAIN.
  - DRAIN: req_valid_out=0. When all pending==0, go to DONE.
  - DONE: flush_done_out=1 for exactly one cycle, then go to RUN.
  - Flush with nothing outstanding: RUN→DRAIN→DONE, so the done pulse appears 2 cycles after flush_req_in is sampled.
- rsp_fire_in is honoured in every state.
- NUM_REQS not a power of 2: rr_ptr wraps at NUM_REQS-1→0. Out-of-range rsp_sel_in raises an assertion and is ignored.

Optional Feature:
- Macro CACHE_SCHED_PERF_EN.
- Defined: per requester, stall_cnt[i] increments each cycle that req_valid_in[i]=1 and pending[i]==MAX_PENDING. It saturates at all-ones and resets to 0. It is exported on stall_cnt_out, with requester i at bits [i*PERF_WIDTH +: PERF_WIDTH].
- Undefined: the port and the logic are absent.

Decomposition:
- Shared package cache_sched_pkg holds:
  - the state enum (RUN, DRAIN, DONE);
  - the SEL_W and CNT_W helper functions;
  - the pending-counter typedef.
- Sub-module rr_credit_picker: combinational round-robin find-first over the eligible vector and rr_ptr, returning winner and any_valid. It is reusable by other arbiters.

Test Plan:
- All 4 requesters valid, MAX_PENDING=4, req_ready_out=1, responses returned immediately → grants in order 0,1,2,3,0,1… with one grant per cycle.
- Requester 2 alone, no responses → exactly 4 fires, then req_valid_out=0. After one rsp_fire_in with sel=2, a fire occurs the following cycle and pending[2] returns to 4.
- req_ready_out=0 for 3 cycles with requester 1 selected, and requester 0 becomes valid meanwhile → req_sel_out stays at 1 until fire, then the next grant goes to 2 or 0 by rr_ptr=2.
- Request fire and response fire to index 3 in the same cycle with pending[3]=2 → pending[3] stays 2.
- 2 outstanding requests, then flush_req_in → no new grants; 2 responses; flush_done_out pulses once, 1 cycle after pending reaches 0; idle_out=1; grants resume.
- Reset asserted mid-burst with 3 outstanding requests → outputs go low immediately; after deassertion pending=0, idle_out=1, and the first grant goes to index 0.

Source files
------------

// File: rtl/cache_sched_pkg.sv
// cache_sched_pkg: shared state enum, sizing helpers and counter type for the cache credit scheduler
package cache_sched_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_e;
    localparam int PEND_CNT_W_MAX = 8;
    typedef logic [PEND_CNT_W_MAX-1:0] pend_cnt_t;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction
endpackage

// File: rtl/rr_credit_picker.sv
// rr_credit_picker: combinational round-robin find-first over an eligibility vector
//   eligible  : requesters allowed to win this cycle
//   rr_ptr    : highest-priority index this cycle (must be < N)
//   winner    : first eligible index at or after rr_ptr, wrapping modulo N
//   any_valid : at least one requester is eligible
module rr_credit_picker #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_valid
);
    logic found;
    int   idx;
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(rr_ptr) + i) % N;
            if (!found && eligible[idx]) begin
                winner = SEL_W'(idx);
                found  = 1'b1;
            end
        end
    end
    assign any_valid = |eligible;
endmodule

// File: rtl/cache_credit_sched.sv
// cache_credit_sched: round-robin, credit-limited request scheduler with flush drain
//   clk, reset      : clock, asynchronous active-high reset
//   req_valid_in    : per-requester request valid
//   req_ready_in    : per-requester ready, one-hot or zero
//   req_valid_out   : granted request valid toward the cache
//   req_sel_out     : index of the granted requester (steers the request mux)
//   req_ready_out   : cache accepts the request
//   rsp_fire_in     : a response was consumed; returns one credit to rsp_sel_in
//   flush_req_in    : level request to drain all outstanding requests
//   flush_done_out  : one-cycle pulse when the drain completes
//   idle_out        : no requests outstanding
//   stall_cnt_out   : per-requester credit-stall counters (CACHE_SCHED_PERF_EN only)
module cache_credit_sched
    import cache_sched_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int MAX_PENDING = 4,
`ifdef CACHE_SCHED_PERF_EN
    parameter int PERF_WIDTH  = 16,
`endif
    localparam int SEL_W = sel_w(NUM_REQS),
    localparam int CNT_W = cnt_w(MAX_PENDING)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_valid_in,
    output logic [NUM_REQS-1:0] req_ready_in,
    output logic                req_valid_out,
    output logic [SEL_W-1:0]    req_sel_out,
    input  logic                req_ready_out,
    input  logic                rsp_fire_in,
    input  logic [SEL_W-1:0]    rsp_sel_in,
    input  logic                flush_req_in,
    output logic                flush_done_out,
    output logic                idle_out
`ifdef CACHE_SCHED_PERF_EN
    ,
    output logic [NUM_REQS*PERF_WIDTH-1:0] stall_cnt_out
`endif
);
    logic [CNT_W-1:0]    pending [NUM_REQS];
    logic [SEL_W-1:0]    rr_ptr, lock_sel, winner;
    logic                lock_valid, any_eligible, fire, all_zero;
    logic [NUM_REQS-1:0] eligible, inc, dec;
    sched_state_e        state;

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid_in[i] && (pending[i] < CNT_W'(MAX_PENDING));
            all_zero    = all_zero && (pending[i] == '0);
        end
    end

    rr_credit_picker #(.N(NUM_REQS), .SEL_W(SEL_W)) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_eligible)
    );

    // A held lock keeps presenting the same requester even if its credit has
    // since run out: that credit was effectively reserved when it first stalled.
    assign req_valid_out  = !reset && (state == RUN) && (lock_valid || any_eligible);
    assign req_sel_out    = lock_valid ? lock_sel : winner;
    assign fire           = req_valid_out && req_ready_out;
    assign req_ready_in   = fire ? (NUM_REQS'(1) << req_sel_out) : '0;
    assign flush_done_out = !reset && (state == DONE);
    assign idle_out       = all_zero;

    // Out-of-range response selects match no index and are therefore ignored.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            inc[i] = fire && (req_sel_out == SEL_W'(i));
            dec[i] = rsp_fire_in && (rsp_sel_in == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) pending[i] <= '0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_sel   <= '0;
            state      <= RUN;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (inc[i] && !dec[i])
                    pending[i] <= pending[i] + 1'b1;
                else if (dec[i] && !inc[i] && pending[i] != '0)
                    pending[i] <= pending[i] - 1'b1;
            end
            if (fire)
                rr_ptr <= (req_sel_out == SEL_W'(NUM_REQS - 1)) ? '0 : req_sel_out + 1'b1;
            if (fire)
                lock_valid <= 1'b0;
            else if (req_valid_out) begin
                lock_valid <= 1'b1;
                lock_sel   <= req_sel_out;
            end
            case (state)
                RUN:     if (flush_req_in && (!lock_valid || fire)) state <= DRAIN;
                DRAIN:   if (all_zero) state <= DONE;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rsp_fire_in) begin
            assert (int'(rsp_sel_in) < NUM_REQS);
            for (int i = 0; i < NUM_REQS; i++)
                if (dec[i] && !inc[i]) assert (pending[i] != '0);
        end
    end

`ifdef CACHE_SCHED_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt [NUM_REQS];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) stall_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++)
                if (req_valid_in[i] && pending[i] == CNT_W'(MAX_PENDING) && stall_cnt[i] != '1)
                    stall_cnt[i] <= stall_cnt[i] + 1'b1;
        end
    end
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_stall
        assign stall_cnt_out[g*PERF_WIDTH +: PERF_WIDTH] = stall_cnt[g];
    end
`endif
endmodule

// File: tb/tb_cache_credit_sched.sv
// tb_cache_credit_sched: directed scoreboard bench for cache_credit_sched
module tb_cache_credit_sched;
    logic       clk, reset;
    logic [3:0] req_valid_in, req_ready_in;
    logic       req_valid_out, req_ready_out, rsp_fire_in, flush_req_in, flush_done_out, idle_out;
    logic [1:0] req_sel_out, rsp_sel_in;
    int         checks = 0;
    int         failures = 0;
    int         exp_q [$];

    cache_credit_sched dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_in   (req_valid_in),
        .req_ready_in   (req_ready_in),
        .req_valid_out  (req_valid_out),
        .req_sel_out    (req_sel_out),
        .req_ready_out  (req_ready_out),
        .rsp_fire_in    (rsp_fire_in),
        .rsp_sel_in     (rsp_sel_in),
        .flush_req_in   (flush_req_in),
        .flush_done_out (flush_done_out),
        .idle_out       (idle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] v, input logic rdy, input logic rf, input int rs, input logic fl);
        req_valid_in  = v;
        req_ready_out = rdy;
        rsp_fire_in   = rf;
        rsp_sel_in    = rs[1:0];
        flush_req_in  = fl;
    endtask

    // Monitor: every accepted grant must match the next expected requester.
    always @(negedge clk) begin
        if (!reset && req_valid_out && req_ready_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got sel %0d expected no grant", req_sel_out);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("grant_sel", 32'(req_sel_out), e);
                check("grant_ready_onehot", 32'(req_ready_in), 32'(1) << e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(4'hF, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        mid();
        check("rst_valid_out", 32'(req_valid_out), 0);
        check("rst_ready_in", 32'(req_ready_in), 0);
        check("rst_done", 32'(flush_done_out), 0);
        check("rst_idle", 32'(idle_out), 1);
        cyc();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        cyc();

        // Round-robin with all valid and immediate responses.
        for (int k = 0; k < 8; k++) begin
            drive(4'hF, 1, k > 0, (k + 3) % 4, 0);
            exp_q.push_back(k % 4);
            cyc();
        end
        drive(0, 1, 1, 3, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        mid();
        check("t1_idle", 32'(idle_out), 1);
        check("t1_drained", exp_q.size(), 0);
        cyc();

        // Requester 2 alone: four credits, then blocked; a response frees one next cycle.
        for (int k = 0; k < 6; k++) begin
            drive(4'b0100, 1, 0, 0, 0);
            if (k < 4) exp_q.push_back(2);
            if (k == 5) begin
                mid();
                check("t2_blocked_at_max", 32'(req_valid_out), 0);
                check("t2_not_idle", 32'(idle_out), 0);
            end
            cyc();
        end
        drive(4'b0100, 1, 1, 2, 0);
        mid();
        check("t2_no_bypass", 32'(req_valid_out), 0);
        cyc();
        drive(4'b0100, 1, 0, 0, 0);
        exp_q.push_back(2);
        cyc();
        mid();
        check("t2_refull_blocked", 32'(req_valid_out), 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 2, 0);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        mid();
        check("t2_idle", 32'(idle_out), 1);
        check("t2_drained", exp_q.size(), 0);
        cyc();

        // Grant lock: rr_ptr=3, requester 1 stalls; requester 0 arriving must not steal it.
        drive(4'b0010, 0, 0, 0, 0);
        mid();
        check("t3_valid_a", 32'(req_valid_out), 1);
        check("t3_sel_a", 32'(req_sel_out), 1);
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(4'b0011, 0, 0, 0, 0);
            mid();
            check("t3_sel_held", 32'(req_sel_out), 1);
            check("t3_no_ready", 32'(req_ready_in), 0);
            cyc();
        end
        drive(4'b0011, 1, 0, 0, 0);
        exp_q.push_back(1);
        cyc();
        drive(4'b0011, 1, 0, 0, 0);
        exp_q.push_back(0);
        cyc();
        drive(0, 1, 1, 1, 0);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        mid();
        check("t3_idle", 32'(idle_out), 1);
        check("t3_drained", exp_q.size(), 0);
        cyc();

        // Same-cycle request and response on index 3 with pending=2 leaves it at 2.
        for (int k = 0; k < 2; k++) begin
            drive(4'b1000, 1, 0, 0, 0);
            exp_q.push_back(3);
            cyc();
        end
        drive(4'b1000, 1, 1, 3, 0);
        exp_q.push_back(3);
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(4'b1000, 1, 0, 0, 0);
            exp_q.push_back(3);
            cyc();
        end
        drive(4'b1000, 1, 0, 0, 0);
        mid();
        check("t4_full_after_two_more", 32'(req_valid_out), 0);
        check("t4_drained", exp_q.size(), 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 3, 0);
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        mid();
        check("t4_idle", 32'(idle_out), 1);
        cyc();

        // Flush with two outstanding requests.
        for (int k = 0; k < 2; k++) begin
            drive(4'b0011, 1, 0, 0, 0);
            exp_q.push_back(k);
            cyc();
        end
        drive(0, 1, 0, 0, 1);
        cyc();
        drive(4'b0011, 1, 0, 0, 0);
        mid();
        check("t5_drain_blocks_a", 32'(req_valid_out), 0);
        cyc();
        drive(4'b0011, 1, 1, 0, 0);
        mid();
        check("t5_drain_blocks_b", 32'(req_valid_out), 0);
        check("t5_no_early_done", 32'(flush_done_out), 0);
        cyc();
        drive(4'b0011, 1, 1, 1, 0);
        mid();
        check("t5_drain_blocks_c", 32'(req_valid_out), 0);
        cyc();
        drive(4'b0011, 1, 0, 0, 0);
        mid();
        check("t5_idle", 32'(idle_out), 1);
        check("t5_done_not_yet", 32'(flush_done_out), 0);
        check("t5_drain_blocks_d", 32'(req_valid_out), 0);
        cyc();
        mid();
        check("t5_done_pulse", 32'(flush_done_out), 1);
        check("t5_done_blocks", 32'(req_valid_out), 0);
        cyc();
        exp_q.push_back(0);
        mid();
        check("t5_done_single", 32'(flush_done_out), 0);
        check("t5_resume", 32'(req_valid_out), 1);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 0);
        mid();
        check("t5e_done_not_yet", 32'(flush_done_out), 0);
        cyc();
        mid();
        check("t5e_done_pulse", 32'(flush_done_out), 1);
        cyc();
        mid();
        check("t5e_done_single", 32'(flush_done_out), 0);
        check("t5_drained", exp_q.size(), 0);
        cyc();

        // Reset mid-burst with three outstanding requests.
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(0);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0111, 1, 0, 0, 0);
            cyc();
        end
        check("t6_not_idle", 32'(idle_out), 0);
        reset = 1'b1;
        #1;
        check("t6_rst_valid_out", 32'(req_valid_out), 0);
        check("t6_rst_ready_in", 32'(req_ready_in), 0);
        check("t6_rst_idle", 32'(idle_out), 1);
        check("t6_rst_done", 32'(flush_done_out), 0);
        cyc();
        reset = 1'b0;
        exp_q.push_back(0);
        mid();
        check("t6_post_idle", 32'(idle_out), 1);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        mid();
        check("t6_idle", 32'(idle_out), 1);
        check("t6_drained", exp_q.size(), 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
